// File: rtl/dir_debouncer.sv
// ============================================================================
// Module   : dir_debouncer
// Brief    : Four-button debouncer with priority direction encode and a press
//            pulse; optional auto-repeat of press when DIR_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic [1:0] dir,
   output logic       dir_valid,
   output logic       press
);

   localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   // Bit order throughout: [3]=up, [2]=down, [1]=left, [0]=right
   logic [3:0] w_raw;
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_deb;
   logic [3:0] r_deb_prev;
   logic       w_rise;
   logic [1:0] w_dir;
   logic       w_dir_valid;
   logic       r_press;

   assign w_raw = {btn_up, btn_down, btn_left, btn_right};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 4'b0000;
         r_sync2 <= 4'b0000;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_btn
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_deb;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
         end else if (r_sync2[i] == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_deb <= r_sync2[i];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_deb[i] = r_deb;
   end

   always_comb begin
      w_dir = 2'b00;
      if (w_deb[3])      w_dir = 2'b00;
      else if (w_deb[2]) w_dir = 2'b01;
      else if (w_deb[1]) w_dir = 2'b10;
      else if (w_deb[0]) w_dir = 2'b11;
   end

   assign w_dir_valid = |w_deb;
   assign w_rise      = |(w_deb & ~r_deb_prev);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_deb_prev <= 4'b0000;
      else     r_deb_prev <= w_deb;
   end

`ifdef DIR_REPEAT_EN
   localparam int c_RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

   logic [c_RPT_W-1:0] r_rpt_cnt;
   logic [1:0]         r_dir_prev;

   // Any release-to-idle, new rise or direction change restarts the period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rpt_cnt  <= '0;
         r_dir_prev <= 2'b00;
         r_press    <= 1'b0;
      end else begin
         r_dir_prev <= w_dir;
         if (!w_dir_valid || w_rise || (w_dir != r_dir_prev)) begin
            r_rpt_cnt <= '0;
            r_press   <= w_rise;
         end else if (r_rpt_cnt == c_RPT_W'(REPEAT_CYCLES - 1)) begin
            r_rpt_cnt <= '0;
            r_press   <= 1'b1;
         end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
            r_press   <= 1'b0;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_press <= 1'b0;
      else     r_press <= w_rise;
   end
`endif

   assign up        = w_deb[3];
   assign down      = w_deb[2];
   assign left      = w_deb[1];
   assign right     = w_deb[0];
   assign dir       = w_dir;
   assign dir_valid = w_dir_valid;
   assign press     = r_press;

endmodule

`default_nettype wire

// File: tb/tb_dir_debouncer.sv
// ============================================================================
// Module   : tb_dir_debouncer
// Brief    : Scoreboard bench for dir_debouncer against a history-window model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dir_debouncer;

   localparam int c_DEB = 4;
   localparam int c_RPT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       up, down, left, right, dir_valid, press;
   logic [1:0] dir;

   int total = 0;
   int bad   = 0;

   dir_debouncer #(.DEBOUNCE_CYCLES(c_DEB), .REPEAT_CYCLES(c_RPT)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .up(up), .down(down), .left(left), .right(right),
      .dir(dir), .dir_valid(dir_valid), .press(press)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] enc(input logic [3:0] d);
      if (d[3]) return 2'b00;
      if (d[2]) return 2'b01;
      if (d[1]) return 2'b10;
      if (d[0]) return 2'b11;
      return 2'b00;
   endfunction

   // Reference model: output changes when the synced level disagreed with the
   // debounced level on each of the last c_DEB edges.
   logic [7:0] exp_q[$];
   logic [3:0] m_raw[$];
   logic [3:0] m_sb[$];
   logic [3:0] m_deb = 4'b0, m_deb_prev = 4'b0;
   int         m_k = 0, m_ref = 0;

   always @(posedge clk) begin : model
      logic [3:0] sb, nd, rise;
      logic       pr, restart, all_diff;
      if (rst) begin
         m_raw.delete(); m_sb.delete();
         m_deb = 4'b0; m_deb_prev = 4'b0; m_k = 0; m_ref = 0;
         exp_q.push_back(8'h00);
      end else begin
         m_k++;
         sb = (m_raw.size() >= 2) ? m_raw[m_raw.size()-2] : 4'b0000;
         m_raw.push_back({btn_up, btn_down, btn_left, btn_right});
         if (m_raw.size() > 2) void'(m_raw.pop_front());
         m_sb.push_back(sb);
         if (m_sb.size() > c_DEB) void'(m_sb.pop_front());
         nd = m_deb;
         for (int b = 0; b < 4; b++) begin
            all_diff = (m_sb.size() == c_DEB);
            foreach (m_sb[j]) if (m_sb[j][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_deb[b];
         end
         rise    = m_deb & ~m_deb_prev;
         restart = (m_deb == 4'b0) || (rise != 4'b0) || (enc(m_deb) != enc(m_deb_prev));
`ifdef DIR_REPEAT_EN
         pr = (rise != 4'b0) || (!restart && (((m_k - m_ref) % c_RPT) == 0));
         if (restart) m_ref = m_k;
`else
         pr = (rise != 4'b0);
`endif
         m_deb_prev = m_deb;
         m_deb      = nd;
         exp_q.push_back({nd, enc(nd), |nd, pr});
      end
   end

   initial begin : monitor
      logic [7:0] e, got;
      forever begin
         @(posedge clk);
         #1;
         got = {up, down, left, right, dir, dir_valid, press};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty t=%0t got=%b required=entry", $time, got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               bad++;
               $display("FAIL outputs t=%0t got=%b required=%b (udlr dir v press)", $time, got, e);
            end
         end
      end
   end

   task automatic hold(input logic [3:0] v, input int n);
      {btn_up, btn_down, btn_left, btn_right} = v;
      repeat (n) @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog t=%0t got=running required=finished", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] got;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      hold(4'b0000, 3);
      hold(4'b1000, 40);
      hold(4'b0000, 10);
      hold(4'b0010, 3);
      hold(4'b0000, 10);
      hold(4'b0101, 20);
      hold(4'b0001, 20);
      hold(4'b0000, 10);
      // Reset mid-operation: outputs must clear without waiting for a clock edge
      hold(4'b0001, 12);
      #2 rst = 1'b1;
      #1 got = {up, down, left, right, dir, dir_valid, press};
      total++;
      if (got !== 8'h00) begin
         bad++;
         $display("FAIL async_reset t=%0t got=%b required=00000000", $time, got);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold(4'b0001, 3);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      hold(4'b0001, 15);
      hold(4'b0000, 10);
      for (int i = 0; i < 300; i++) begin
         hold(4'($urandom_range(0, 15)), $urandom_range(1, 8));
      end
      hold(4'b0000, 10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dir_debouncer.md
DIR_DEBOUNCER -- requirements
Module: dir_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable clock cycles required to accept a new button level (5 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 10000000, auto-repeat period in clock cycles; used only when DIR_REPEAT_EN is defined; legal range >= 2.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_up, btn_down, btn_left, btn_right  input  1 each  raw pushbutton levels, asynchronous to clk, active-high.
REQ-006 up, down, left, right  output  1 each  debounced registered button levels; these feed the button stage directly.
REQ-007 dir  output  2  encoded direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 dir_valid  output  1  high when any debounced button is high.
REQ-009 press  output  1  single-cycle registered pulse marking a new direction press.

Function
REQ-010 Each raw input SHALL pass through a two-flop synchronizer before any other logic; the second flop is the synced level s.
REQ-011 Each button SHALL have an independent counter; while s equals the debounced level, the counter SHALL be held at 0.
REQ-012 While s differs from the debounced level, the counter SHALL increment each cycle; on the edge where it equals DEBOUNCE_CYCLES-1 and s still differs, the debounced level SHALL take s and the counter SHALL return to 0.
REQ-013 A clean raw transition before edge 1 SHALL change the debounced output on exactly edge DEBOUNCE_CYCLES+2.
REQ-014 A glitch that returns s to the debounced level before the count completes SHALL clear the counter and leave the output unchanged.
REQ-015 The counter width SHALL be the minimum width that holds DEBOUNCE_CYCLES-1; the counter SHALL never wrap.
REQ-016 dir SHALL be a combinational priority encode of the debounced levels: up > down > left > right. When no button is high, dir SHALL be 00 and dir_valid SHALL be 0.
REQ-017 press SHALL assert for exactly one cycle on the edge after any debounced level rises 0->1; simultaneous rises on several buttons SHALL produce one pulse.
REQ-018 A debounced fall SHALL never generate press.

Reset
REQ-019 rst high SHALL immediately clear all synchronizer flops, counters, debounced levels, press and any repeat state; up/down/left/right/dir_valid/press read 0 and dir reads 00.
REQ-020 Reset asserted mid-count SHALL discard the partial count; after release, a held button SHALL need the full DEBOUNCE_CYCLES+2 edges again.

Configuration
REQ-021 Macro DIR_REPEAT_EN: when defined, while dir_valid stays high and dir is unchanged, press SHALL re-pulse every REPEAT_CYCLES cycles after the previous pulse. A change in dir SHALL restart the period. dir_valid falling SHALL clear the repeat counter.
REQ-022 Without DIR_REPEAT_EN, press SHALL occur only per REQ-017, and no repeat counter SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-023 btn_up 0->1 before edge 1, held -> up=1, dir=00, dir_valid=1 from edge 6; press=1 only in the cycle after edge 7.
REQ-024 btn_left pulses high for 3 cycles, then low -> left stays 0, press never asserts.
REQ-025 btn_down and btn_right rise together and are held -> dir=01, a single press pulse; btn_down released and debounced -> dir=11, no new press without DIR_REPEAT_EN.
REQ-026 btn_right held, rst pulsed at edge 4 -> all outputs 0 during reset; right=1 exactly 6 edges after rst deasserts.
REQ-027 With DIR_REPEAT_EN, btn_up held 30 cycles after debounce -> press at the initial press cycle, then every 8 cycles (3 repeats); without the macro -> one pulse only.
